// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM peripheral.
package pwm_pkg;

    // Counter alignment held in the mode shadow register
    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    // Count direction; only center-aligned mode ever counts down
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    // Largest counter/duty value for a given width (2^width - 1)
    function automatic int cnt_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage : pwm_pkg

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, up/up-down counter and period boundary
// detection, with presc/mode shadows that reload only on a boundary.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PRESC_W-1:0] presc,
    input  logic               center_mode,
    output logic [CNT_W-1:0]   cnt,
    output logic               boundary
);

    localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(cnt_max(CNT_W) - 1);

    logic [PRESC_W-1:0] pcnt;
    logic [PRESC_W-1:0] presc_act;
    pwm_mode_e          mode_act;
    pwm_dir_e           dir;
    logic               tick;

    assign tick = (pcnt == presc_act);

    // Period end: last up-count in edge mode, last down-count in center mode
    always_comb begin
        if (mode_act == PWM_EDGE) begin
            boundary = tick && (cnt == MAX_M1);
        end else begin
            boundary = tick && (dir == DIR_DOWN) && (cnt == CNT_W'(1));
        end
    end

    // Prescaler, counter and direction; shadows reload on the boundary
    // NOTE: sequential state uses <= so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt      <= '0;
            cnt       <= '0;
            dir       <= DIR_UP;
            presc_act <= '0;
            mode_act  <= PWM_EDGE;
        end else begin
            pcnt <= tick ? '0 : pcnt + PRESC_W'(1);
            if (boundary) begin
                cnt       <= '0;
                dir       <= DIR_UP;
                presc_act <= presc;
                mode_act  <= center_mode ? PWM_CENTER : PWM_EDGE;
            end else if (tick) begin
                if (dir == DIR_DOWN) begin
                    cnt <= cnt - CNT_W'(1);
                end else if (cnt == MAX_M1) begin
                    // Only reachable in center mode: turn around at the top
                    dir <= DIR_DOWN;
                    cnt <= cnt - CNT_W'(1);
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule : pwm_timebase

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM: one shared timebase feeding NUM_CH comparators, each
// with a pending/active duty pair so duty changes land on period boundaries.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int NUM_CH  = 16,
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         en_out,
    input  logic [NUM_CH-1:0]         en_pwm,
    input  logic [PRESC_W-1:0]        presc,
    input  logic                      center_mode,
    input  logic                      duty_wr,
    input  logic [$clog2(NUM_CH)-1:0] duty_ch,
    input  logic [CNT_W-1:0]          duty_val,
    output logic [NUM_CH-1:0]         out,
    output logic                      period_tick
);

    localparam int CH_W = $clog2(NUM_CH);

    logic [CNT_W-1:0]  cnt;
    logic              boundary;
    logic [NUM_CH-1:0] out_next;

    pwm_timebase #(
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk         (clk),
        .rst_n       (rst_n),
        .presc       (presc),
        .center_mode (center_mode),
        .cnt         (cnt),
        .boundary    (boundary)
    );

    assign period_tick = boundary;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic             wr_hit;
        logic [CNT_W-1:0] pending;
        logic [CNT_W-1:0] duty_act;

        // Out-of-range channel indices match no channel and are dropped
        assign wr_hit = duty_wr && (duty_ch == CH_W'(i));

        // Capture writes into pending; promote to active on the boundary,
        // forwarding a write that lands in the boundary cycle itself
        // NOTE: pending registers are reset explicitly so a reset discards
        // writes that had not yet reached a boundary.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pending  <= '0;
                duty_act <= '0;
            end else begin
                if (wr_hit) begin
                    pending <= duty_val;
                end
                if (boundary) begin
                    duty_act <= wr_hit ? duty_val : pending;
                end
            end
        end

        // Disabled output is low; enabled without PWM is static high
        assign out_next[i] = en_out[i] && (!en_pwm[i] || (cnt < duty_act));
    end

    // Register the selected outputs so the pins are glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= out_next;
        end
    end

endmodule : pwm_multichannel

// File: tb/tb_pwm_multichannel.sv
// Directed testbench for pwm_multichannel: reset, edge duty, extremes and
// static modes, prescaler, duty shadowing and center-aligned operation.
module tb_pwm_multichannel;

    localparam int NUM_CH  = 12;
    localparam int CNT_W   = 8;
    localparam int PRESC_W = 8;
    localparam int CH_W    = $clog2(NUM_CH);

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NUM_CH-1:0]   en_out;
    logic [NUM_CH-1:0]   en_pwm;
    logic [PRESC_W-1:0]  presc;
    logic                center_mode;
    logic                duty_wr;
    logic [CH_W-1:0]     duty_ch;
    logic [CNT_W-1:0]    duty_val;
    logic [NUM_CH-1:0]   out;
    logic                period_tick;

    int checks   = 0;
    int failures = 0;

    // Window statistics filled in by measure()
    int                highs [NUM_CH];
    int                falls [NUM_CH];
    int                rises [NUM_CH];
    logic [NUM_CH-1:0] first_out;
    logic [NUM_CH-1:0] last_out;
    int                ticks;
    int                tick_idx;

    always #5 clk = ~clk;

    pwm_multichannel #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_out      (en_out),
        .en_pwm      (en_pwm),
        .presc       (presc),
        .center_mode (center_mode),
        .duty_wr     (duty_wr),
        .duty_ch     (duty_ch),
        .duty_val    (duty_val),
        .out         (out),
        .period_tick (period_tick)
    );

    // Sample len consecutive falling edges; write strobes last one clock
    task automatic measure(input int len);
        logic [NUM_CH-1:0] prev;
        prev     = '0;
        ticks    = 0;
        tick_idx = -1;
        for (int c = 0; c < NUM_CH; c++) begin
            highs[c] = 0;
            falls[c] = 0;
            rises[c] = 0;
        end
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            duty_wr = 1'b0;
            if (period_tick === 1'b1) begin
                ticks++;
                tick_idx = k;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (out[c] === 1'b1) highs[c]++;
                if (k > 0 && prev[c] && !out[c]) falls[c]++;
                if (k > 0 && !prev[c] && out[c]) rises[c]++;
            end
            if (k == 0) first_out = out;
            prev = out;
        end
        last_out = prev;
    endtask

    // Advance to the next falling edge on which period_tick is high
    task automatic align(input int limit, output int waited);
        waited = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            duty_wr = 1'b0;
            if (period_tick === 1'b1) begin
                waited = i;
                break;
            end
        end
        checks++;
        if (waited < 0) begin
            failures++;
            $display("FAIL align: no period_tick within %0d clocks", limit);
        end
    endtask

    task automatic test_reset();
        int seen;
        int k;
        int bad;
        logic [NUM_CH-1:0] bad_val;
        logic [CNT_W-1:0] init_duty [5];
        init_duty = '{8'd128, 8'd0, 8'd255, 8'd0, 8'd200};

        rst_n = 1'b0; en_out = '1; en_pwm = '0; presc = '0;
        center_mode = 1'b0; duty_wr = 1'b0; duty_ch = '0; duty_val = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (out !== '0 || period_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_initial: out=%h tick=%b, expected 000/0", out, period_tick);
        end

        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (out !== 12'hfff) begin
            failures++;
            $display("FAIL static_high_all: out=%h expected fff", out);
        end

        // Pending write to ch5 that the coming reset must discard
        duty_ch = CH_W'(5); duty_val = 8'd99; duty_wr = 1'b1;
        @(negedge clk);
        duty_wr = 1'b0;

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out !== '0 || period_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: out=%h tick=%b, expected 000/0", out, period_tick);
        end

        repeat (2) @(negedge clk);
        en_out = 12'hfef;  // ch4 output disabled
        en_pwm = 12'hff7;  // ch3 static high
        @(negedge clk);
        rst_n = 1'b1;

        seen = 0; k = -1; bad = 0; bad_val = '0;
        for (int i = 1; i <= 300 && seen == 0; i++) begin
            @(negedge clk);
            duty_wr = 1'b0;
            if (period_tick === 1'b1) begin
                seen = 1;
                k    = i;
            end else if (out !== 12'h008) begin
                bad++;
                bad_val = out;
            end
            if (i <= 5) begin
                duty_wr  = 1'b1;
                duty_ch  = CH_W'(i - 1);
                duty_val = init_duty[i-1];
            end
        end
        duty_wr = 1'b0;
        checks++;
        if (k !== 254) begin
            failures++;
            $display("FAIL first_boundary: tick after %0d clocks, expected 254", k);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL first_period_out: %0d bad clocks (e.g. out=%h), expected 008", bad, bad_val);
        end
    endtask

    task automatic test_edge_duty();
        int exp_h [NUM_CH] = '{128, 0, 255, 255, 0, 0, 0, 0, 0, 0, 0, 0};
        @(negedge clk);
        measure(255);
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (highs[c] !== exp_h[c]) begin
                failures++;
                $display("FAIL edge_highs ch%0d: got %0d expected %0d", c, highs[c], exp_h[c]);
            end
        end
        checks++;
        if (first_out[0] !== 1'b1 || last_out[0] !== 1'b0 || falls[0] !== 1 || rises[0] !== 0) begin
            failures++;
            $display("FAIL edge_shape ch0: first=%b last=%b falls=%0d rises=%0d expected 1/0/1/0",
                     first_out[0], last_out[0], falls[0], rises[0]);
        end
        checks++;
        if (ticks !== 1 || tick_idx !== 253) begin
            failures++;
            $display("FAIL edge_period: ticks=%0d at %0d expected 1 at 253", ticks, tick_idx);
        end
    endtask

    task automatic test_prescaler();
        int waited;
        int exp_h [NUM_CH] = '{256, 0, 1020, 1020, 0, 0, 0, 0, 0, 0, 0, 0};
        presc = 8'd3;
        duty_ch = CH_W'(0); duty_val = 8'd64; duty_wr = 1'b1;
        align(300, waited);
        @(negedge clk);
        presc = 8'd0;  // mid-period change must wait for the boundary
        measure(1020);
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (highs[c] !== exp_h[c]) begin
                failures++;
                $display("FAIL presc_highs ch%0d: got %0d expected %0d", c, highs[c], exp_h[c]);
            end
        end
        checks++;
        if (ticks !== 1 || tick_idx !== 1018) begin
            failures++;
            $display("FAIL presc_period: ticks=%0d at %0d expected 1 at 1018", ticks, tick_idx);
        end
    endtask

    task automatic test_shadow();
        int waited;
        duty_ch = CH_W'(0); duty_val = 8'd128; duty_wr = 1'b1;
        align(300, waited);
        @(negedge clk);
        duty_ch = CH_W'(0); duty_val = 8'd200; duty_wr = 1'b1;
        measure(255);
        checks++;
        if (highs[0] !== 128 || ticks !== 1 || tick_idx !== 253) begin
            failures++;
            $display("FAIL shadow_current: highs=%0d tick_at=%0d expected 128/253", highs[0], tick_idx);
        end
        measure(255);
        checks++;
        if (highs[0] !== 200 || ticks !== 1 || tick_idx !== 253) begin
            failures++;
            $display("FAIL shadow_next: highs=%0d tick_at=%0d expected 200/253", highs[0], tick_idx);
        end
    endtask

    task automatic test_back_to_back();
        int waited;
        align(300, waited);
        // Write landing in the boundary cycle itself
        duty_ch = CH_W'(0); duty_val = 8'd50; duty_wr = 1'b1;
        @(negedge clk);
        duty_wr = 1'b0;
        measure(255);
        checks++;
        if (highs[0] !== 50) begin
            failures++;
            $display("FAIL coincident_write: highs=%0d expected 50", highs[0]);
        end
    endtask

    task automatic test_ignored_write();
        int waited;
        int exp_h [NUM_CH] = '{50, 0, 255, 255, 0, 0, 0, 0, 0, 0, 0, 0};
        duty_ch = CH_W'(NUM_CH); duty_val = 8'd7; duty_wr = 1'b1;
        align(300, waited);
        @(negedge clk);
        measure(255);
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (highs[c] !== exp_h[c]) begin
                failures++;
                $display("FAIL ignored_write ch%0d: highs=%0d expected %0d", c, highs[c], exp_h[c]);
            end
        end
    endtask

    task automatic test_center();
        int waited;
        center_mode = 1'b1;
        duty_ch = CH_W'(0); duty_val = 8'd100; duty_wr = 1'b1;
        align(600, waited);
        checks++;
        if (waited !== 254) begin
            failures++;
            $display("FAIL center_switch_delay: tick after %0d clocks, expected 254", waited);
        end
        @(negedge clk);
        measure(508);
        checks++;
        if (highs[0] !== 199 || highs[2] !== 508 || highs[1] !== 0) begin
            failures++;
            $display("FAIL center_highs: ch0=%0d ch1=%0d ch2=%0d expected 199/0/508",
                     highs[0], highs[1], highs[2]);
        end
        checks++;
        if (first_out[0] !== 1'b1 || last_out[0] !== 1'b1 || falls[0] !== 1 || rises[0] !== 1) begin
            failures++;
            $display("FAIL center_shape ch0: first=%b last=%b falls=%0d rises=%0d expected 1/1/1/1",
                     first_out[0], last_out[0], falls[0], rises[0]);
        end
        checks++;
        if (ticks !== 1 || tick_idx !== 506) begin
            failures++;
            $display("FAIL center_period: ticks=%0d at %0d expected 1 at 506", ticks, tick_idx);
        end
    endtask

    initial begin
        test_reset();
        test_edge_duty();
        test_prescaler();
        test_shadow();
        test_back_to_back();
        test_ignored_write();
        test_center();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_pwm_multichannel

// File: doc/pwm_multichannel.md
# pwm_multichannel

Parametrised multi-channel PWM peripheral; the generalised successor to the fixed 16-output, 8-bit PWM block. One shared timebase (programmable prescaler, edge- or center-aligned counter) drives NUM_CH comparators. Each comparator has a double-buffered duty register, so period-glitch-free updates are guaranteed. Sits behind the register interface, and its outputs map onto the chip's dedicated and bidirectional output pins.

## Interface
Parameters:
- NUM_CH, 16, number of PWM channels / output bits
- CNT_W, 8, counter and duty width; MAX = 2^CNT_W − 1
- PRESC_W, 8, prescaler width

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- en_out  in  NUM_CH  per-channel output enable (0 forces output low)
- en_pwm  in  NUM_CH  per-channel PWM enable (0 with en_out=1 gives static high)
- presc  in  PRESC_W  counter advances every presc+1 clocks (shadowed)
- center_mode  in  1  0 = edge-aligned, 1 = center-aligned (shadowed)
- duty_wr  in  1  single-cycle duty write strobe
- duty_ch  in  $clog2(NUM_CH)  channel index for duty_wr; indices ≥ NUM_CH are ignored
- duty_val  in  CNT_W  duty value written to that channel's pending register
- out  out  NUM_CH  PWM outputs, registered
- period_tick  out  1  one-clock pulse on each shadow-load boundary

## Operation
- Prescaler: pcnt counts 0..presc_act. tick = (pcnt == presc_act). pcnt wraps to 0 on tick.
- Edge mode: cnt advances on tick through 0..MAX−1 and wraps to 0. Period = MAX ticks. The boundary is the tick with cnt == MAX−1.
- Center mode: cnt runs 0,1..MAX−1, then MAX−2..1, then 0 (dir flag). Period = 2·MAX−2 ticks. The boundary is the tick with dir = down and cnt == 1.
- Boundary load, all in one clock:
  - duty_act[i] ← pending[i], including a duty_wr landing in that same cycle
  - presc_act ← presc
  - mode_act ← center_mode
  - cnt ← 0, dir ← up
  - period_tick = 1
- Compare: pwm[i] = (cnt < duty_act[i]). duty 0 gives a constant low output. duty MAX gives a constant high output.
- Output selection: out[i] ← en_out[i] ? (en_pwm[i] ? pwm[i] : 1) : 0.
- en_out and en_pwm are not shadowed; they take effect on the next clock.
- duty_wr writes only pending[duty_ch]. Active duty is unchanged until the next boundary.

## Timing
- Reset (asynchronous assert, synchronous-safe release) forces:
  - out = 0, period_tick = 0
  - cnt = 0, dir = up, pcnt = 0
  - all pending and duty_act = 0
  - presc_act = 0, mode_act = edge
- After release, the first boundary occurs at the end of the first full period. Until then duty_act = 0, so enabled PWM channels stay low.
- out has 1-clock latency from the cnt/duty_act state it reflects. period_tick is combinational from the boundary condition and is asserted in the load cycle.
- Reset mid-period aborts the period immediately. Pending writes are lost.
- A presc or center_mode change mid-period has no effect until the boundary.
- Edge-mode high time = duty·(presc+1) clocks per period.
- Center-mode high time = (2·duty−1)·(presc+1) clocks per period for 0 < duty < MAX. The high pulse is contiguous and centred on cnt = 0.

## Structure
- Shared package pwm_pkg holds:
  - mode enum (PWM_EDGE, PWM_CENTER)
  - dir enum
  - helper localparam function for MAX
- Sub-module pwm_timebase contains the prescaler, counter, dir and boundary/tick generation, plus the mode_act/presc_act shadows. It outputs cnt and boundary.
- The top instantiates pwm_timebase once. The per-channel pending/active registers, comparators and output muxes are built with a generate loop.

## Test plan
- Reset behaviour: assert rst_n=0 mid-period with en_out=all 1 → out=0 within the same clock, period_tick=0. After release, out stays 0 until the first boundary.
- Edge duty: presc=0, duty ch0=128, en_out[0]=en_pwm[0]=1 → after the first period_tick, out[0] is high for 128 clocks and low for 127, repeating every 255 clocks.
- Extremes and static modes:
  - ch1 duty=0 → out[1] constant 0
  - ch2 duty=255 → out[2] constant 1
  - ch3 with en_out=1, en_pwm=0 → constant 1
  - ch4 with en_out=0 → constant 0
- Prescaler: presc=3, duty=64 → period 1020 clocks, high 256 clocks.
- Shadowing:
  - duty 128→200 written mid-period → the current period keeps 128 high clocks, the next gives 200.
  - A write coincident with period_tick applies to the period starting in that cycle.
  - A write to duty_ch=NUM_CH is ignored.
- Center mode: center_mode=1, presc=0, duty=100 → period 508 clocks with 199 contiguous high clocks centred on cnt=0. The mode switch takes effect only at the boundary.
